// File: rtl/shared_adder41_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : shared_adder41_arbiter_if
//  Description : Handshake bundle between the requesters/response consumer
//                and the shared 41+7-bit adder arbiter.
//                  req_valid[i] / req_ready[i] : per-requester handshake
//                  req_a  (NUM_REQ*41)         : packed A operands
//                  req_b  (NUM_REQ*7)          : packed B operands
//                  rsp_valid / rsp_ready       : response handshake
//                  rsp_sum (42), rsp_id (ID_W) : registered result and tag
//                master : requester / consumer side
//                slave  : arbiter side
//  Revision    : 1.0 - initial release
// ============================================================================
interface shared_adder41_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*41-1:0] req_a;
  logic [NUM_REQ*7-1:0]  req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [41:0]           rsp_sum;
  logic [ID_W-1:0]       rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id
  );
endinterface
`default_nettype wire

// File: rtl/shared_adder41_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : shared_adder41_arbiter
//  Description : Round-robin arbiter sharing one 41-bit + 7-bit unsigned
//                adder among NUM_REQ requesters. At most one operand pair is
//                accepted per cycle; the 42-bit sum is returned through a
//                single registered, back-pressurable response port tagged
//                with the requester index.
//  Ports       : clk        - clock, rising edge
//                rst_n      - asynchronous active-low reset
//                bus        - slave side of shared_adder41_arbiter_if
//                             (request handshakes/operands, response port)
//                busy       - response held or any request pending
//                txn_count  - accepted-request counter, wraps at 16 bits
//  Revision    : 1.0 - initial release
// ============================================================================
module shared_adder41_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  shared_adder41_arbiter_if.slave   bus,
  output logic                      busy,
  output logic [15:0]               txn_count
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          r_state;
  logic [ID_W-1:0] r_ptr;
  logic [41:0]     r_sum;
  logic [ID_W-1:0] r_id;
  logic [15:0]     r_txn_count;

  logic            w_found;
  logic [ID_W-1:0] w_grant;
  logic [ID_W-1:0] w_idx;
  logic            w_can_accept;
  logic            w_accept;
  logic [40:0]     w_a;
  logic [6:0]      w_b;
  logic [41:0]     w_sum;

  // Rotating priority search starting at r_ptr. NUM_REQ is a power of two,
  // so the ID_W-bit addition wraps modulo NUM_REQ for free.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = r_ptr + ID_W'(k);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  // rst_n gating keeps req_ready low while reset is asserted, since the
  // EMPTY reset state would otherwise advertise capacity.
  assign w_can_accept = (r_state == EMPTY) || bus.rsp_ready;
  assign w_accept     = w_found && w_can_accept && rst_n;

  always_comb begin
    bus.req_ready = '0;
    if (w_accept) begin
      bus.req_ready[w_grant] = 1'b1;
    end
  end

  // Operand mux feeding the single shared adder instance.
  assign w_a   = bus.req_a[int'(w_grant)*41 +: 41];
  assign w_b   = bus.req_b[int'(w_grant)*7 +: 7];
  // Bit 41 carries out; no truncation of the result.
  assign w_sum = {1'b0, w_a} + {35'b0, w_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_ptr       <= '0;
      r_sum       <= '0;
      r_id        <= '0;
      r_txn_count <= '0;
    end else begin
      if (w_accept) begin
        // Covers both a fresh load and a simultaneous consume+load.
        r_state     <= FULL;
        r_sum       <= w_sum;
        r_id        <= w_grant;
        r_ptr       <= w_grant + ID_W'(1);
        r_txn_count <= r_txn_count + 16'd1;
      end else if ((r_state == FULL) && bus.rsp_ready) begin
        // Sum and id intentionally keep their last values.
        r_state <= EMPTY;
      end
    end
  end

  assign bus.rsp_valid = (r_state == FULL);
  assign bus.rsp_sum   = r_sum;
  assign bus.rsp_id    = r_id;
  assign txn_count     = r_txn_count;
  assign busy          = (r_state == FULL) || (|bus.req_valid);

endmodule
`default_nettype wire

// File: tb/tb_shared_adder41_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shared_adder41_arbiter
//  Description : Scoreboard bench for shared_adder41_arbiter. The stimulus
//                process drives directed vectors and pushes the expected
//                {sum, id} of every accepted request; a monitor process pops
//                and compares each response as it is consumed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_adder41_arbiter;

  localparam int c_NUM_REQ = 4;
  localparam int c_ID_W    = 2;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [15:0] txn_count;

  logic [40:0] r_a [c_NUM_REQ];
  logic [6:0]  r_b [c_NUM_REQ];

  logic [43:0] sb [$];
  int          checks;
  int          errors;

  shared_adder41_arbiter_if #(.NUM_REQ(c_NUM_REQ), .ID_W(c_ID_W)) bus ();

  shared_adder41_arbiter #(.NUM_REQ(c_NUM_REQ), .ID_W(c_ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .txn_count (txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < c_NUM_REQ; i++) begin
      bus.req_a[i*41 +: 41] = r_a[i];
      bus.req_b[i*7 +: 7]   = r_b[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus. g < 0 means no grant is expected.
  task automatic cycle(input logic [3:0] vmask, input logic rr, input int g, input logic [41:0] s);
    logic [3:0] exp_rdy;
    bus.req_valid = vmask;
    bus.rsp_ready = rr;
    @(negedge clk);
    exp_rdy = (g < 0) ? 4'b0000 : (4'b0001 << g);
    chk("req_ready", {60'd0, bus.req_ready}, {60'd0, exp_rdy});
    if (g >= 0) sb.push_back({s, 2'(g)});
    @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed response must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        logic [43:0] e;
        e = sb.pop_front();
        chk("rsp_sum", {22'd0, bus.rsp_sum}, {22'd0, e[43:2]});
        chk("rsp_id", {62'd0, bus.rsp_id}, {62'd0, e[1:0]});
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [41:0] s;
    int exp_g [8];
    exp_g = '{1, 2, 3, 0, 1, 2, 3, 0};

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < c_NUM_REQ; i++) begin
      r_a[i] = '0;
      r_b[i] = '0;
    end

    // ---- Reset state, including req_ready held low with requests pending
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rst_rsp_sum", {22'd0, bus.rsp_sum}, 64'd0);
    chk("rst_rsp_id", {62'd0, bus.rsp_id}, 64'd0);
    chk("rst_txn_count", {48'd0, txn_count}, 64'd0);
    chk("rst_busy_idle", {63'd0, busy}, 64'd0);
    bus.req_valid = 4'b1111;
    #1;
    chk("rst_req_ready", {60'd0, bus.req_ready}, 64'd0);
    chk("rst_busy_req", {63'd0, busy}, 64'd1);
    bus.req_valid = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ---- Single request at the arithmetic maximum
    r_a[0] = 41'h1FFFFFFFFFF;
    r_b[0] = 7'h7F;
    cycle(4'b0001, 1'b1, 0, 42'h2000000007E);
    chk("single_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
    chk("single_txn_count", {48'd0, txn_count}, 64'd1);
    cycle(4'b0000, 1'b1, -1, '0);
    chk("drained_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);

    // ---- Round robin, all valid, A=i B=1 (pointer sits at 1)
    for (int i = 0; i < c_NUM_REQ; i++) begin
      r_a[i] = 41'(i);
      r_b[i] = 7'd1;
    end
    for (int k = 0; k < 8; k++) begin
      cycle(4'b1111, 1'b1, exp_g[k], 42'(exp_g[k] + 1));
    end

    // ---- Backpressure: result (sum 1, id 0) held for 3 cycles
    for (int k = 0; k < 3; k++) begin
      cycle(4'b1111, 1'b0, -1, '0);
      chk("bp_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
      chk("bp_rsp_sum", {22'd0, bus.rsp_sum}, 64'd1);
      chk("bp_rsp_id", {62'd0, bus.rsp_id}, 64'd0);
    end
    chk("bp_txn_count", {48'd0, txn_count}, 64'd9);
    // Pointer unchanged: requester 1 is granted in the release cycle.
    cycle(4'b1111, 1'b1, 1, 42'd2);

    // ---- Pointer skip: grant 2, then only 1 and 3 valid
    cycle(4'b0100, 1'b1, 2, 42'd3);
    cycle(4'b1010, 1'b1, 3, 42'd4);
    cycle(4'b1010, 1'b1, 1, 42'd2);
    cycle(4'b0000, 1'b1, -1, '0);

    // ---- Reset mid-operation with a held response
    cycle(4'b0001, 1'b1, 0, 42'd1);
    cycle(4'b0000, 1'b0, -1, '0);
    chk("pre_rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("mid_rst_rsp_sum", {22'd0, bus.rsp_sum}, 64'd0);
    chk("mid_rst_txn_count", {48'd0, txn_count}, 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Pointer would be 1 without reset, which would pick requester 2.
    cycle(4'b0101, 1'b1, 0, 42'd1);
    cycle(4'b0100, 1'b1, 2, 42'd3);
    cycle(4'b0000, 1'b1, -1, '0);
    chk("post_rst_txn_count", {48'd0, txn_count}, 64'd2);

    // ---- Counter wrap: 65534 more accepts bring the total to 65536
    r_a[0] = 41'h155_5555_5555;  r_b[0] = 7'h2A;
    r_a[1] = 41'h0AA_AAAA_AAAA;  r_b[1] = 7'h55;
    r_a[2] = 41'h1FF_FFFF_FF80;  r_b[2] = 7'h7F;
    r_a[3] = 41'h000_0000_0001;  r_b[3] = 7'h00;
    g = 3;
    for (int k = 0; k < 65534; k++) begin
      s = {1'b0, r_a[g]} + {35'd0, r_b[g]};
      cycle(4'b1111, 1'b1, g, s);
      g = (g + 1) % c_NUM_REQ;
    end
    chk("wrap_txn_count", {48'd0, txn_count}, 64'd0);
    cycle(4'b0100, 1'b1, 2, 42'h1FFFFFFFFFF);
    chk("post_wrap_txn_count", {48'd0, txn_count}, 64'd1);
    cycle(4'b0000, 1'b1, -1, '0);
    cycle(4'b0000, 1'b1, -1, '0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shared_adder41_arbiter.md
# shared_adder41_arbiter

Round-robin arbiter and sequencer that shares one 41-bit + 7-bit unsigned add datapath (`customAdder41_34`: 41-bit A plus zero-extended 7-bit B, 42-bit sum) among several requesters. It accepts at most one operand pair per cycle over valid/ready handshakes and computes the sum on the shared adder. The result is returned through a single registered, back-pressurable response port tagged with the requester index. It sits between the partial-product/exponent stages that issue small-increment additions and the single adder instance.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; power of two, 2..8.
- `ID_W`, default 2: `$clog2(NUM_REQ)`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  bit i: requester i presents an operand pair.
- `req_ready`  out  NUM_REQ  bit i: requester i's pair is accepted this cycle; one-hot or zero.
- `req_a`  in  NUM_REQ*41  requester i's A is in bits [41*i+40 : 41*i].
- `req_b`  in  NUM_REQ*7  requester i's B is in bits [7*i+6 : 7*i].
- `rsp_valid`  out  1  response register holds a result.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_sum`  out  42  registered A + {34'b0, B}.
- `rsp_id`  out  ID_W  index of the requester that produced `rsp_sum`.
- `busy`  out  1  high when `rsp_valid` is high or any `req_valid` bit is high.
- `txn_count`  out  16  number of accepted requests; wraps 0xFFFF→0.

## Operation
- Two states:
  - `EMPTY`: response register empty.
  - `FULL`: response register holds an unconsumed result.
- Capacity: `can_accept = (state==EMPTY) || rsp_ready`.
- Round-robin pointer `ptr` (ID_W bits):
  - Grant goes to the first i with `req_valid[i]`, searching from `ptr` upward modulo NUM_REQ.
  - On each accept, `ptr` ← grant+1 (mod NUM_REQ).
  - With no accept, `ptr` holds.
- `req_ready[g]` = `can_accept` and g is the granted index. All other bits are 0.
- Handshake dependencies:
  - `req_ready` may depend combinationally on `req_valid` and `rsp_ready`.
  - Requesters must not make `req_valid` depend on `req_ready`.
- On accept (`req_valid[g] && req_ready[g]`):
  - The adder is driven with `req_a[g]` and `req_b[g]`.
  - `rsp_sum` ← 42-bit sum, `rsp_id` ← g, state ← FULL, `txn_count` += 1.
- Response consumed with no new accept (`rsp_valid && rsp_ready`): state ← EMPTY. `rsp_sum` and `rsp_id` hold their last values.
- Simultaneous consume and accept: the new result is loaded, state stays FULL, throughput is 1 per cycle.
- While `rsp_valid && !rsp_ready`:
  - `rsp_sum` and `rsp_id` are held stable.
  - All `req_ready` bits are 0.
  - `ptr` holds.
- Arithmetic:
  - Unsigned, no truncation. Maximum result is 2^41−1+127 = 0x2000000007E.
  - Bit 41 is the carry-out; no overflow flag.
- Requester input contract: a requester with `req_valid` high keeps `req_a`/`req_b` stable until it sees `req_ready`. The block does not check this.

## Timing
- Reset values (asynchronous on `rst_n`=0, released synchronously by design of the reset tree):
  - `rsp_valid`=0, `rsp_sum`=0, `rsp_id`=0, `ptr`=0, state=EMPTY, `txn_count`=0.
  - `req_ready`=0.
  - `busy` follows its equation.
- Reset mid-operation: a held response is discarded and no handshake completes in the reset cycle. The first grant after reset searches from index 0.
- Latency: accept at edge N → `rsp_valid`=1 and `rsp_sum` valid after edge N, i.e. 1 cycle.
- Adder path: combinational within one cycle from the operand mux to the `rsp_sum` register. The adder must meet timing at the system clock.
- Fairness: with all requesters continuously valid and `rsp_ready`=1, each requester is granted once every NUM_REQ cycles.
- Worst-case wait for a valid requester is NUM_REQ−1 accepts by other requesters.

## Test plan
- Reset then single request:
  - Stimulus: `req_valid`=0001, A=0x1FFFFFFFFFF, B=0x7F, `rsp_ready`=1.
  - Response: `req_ready`=0001 in the same cycle; next cycle `rsp_valid`=1, `rsp_sum`=0x2000000007E, `rsp_id`=0, `txn_count`=1.
- All four requesters continuously valid, A=i, B=1, `rsp_ready`=1:
  - Grants 0,1,2,3,0,1… on consecutive cycles.
  - `rsp_sum` = 1,2,3,4,1,…; one response per cycle.
- Backpressure:
  - Stimulus: with a result held, drive `rsp_ready`=0 for 3 cycles while all requesters are valid.
  - Response: `rsp_sum`/`rsp_id` stable, `req_ready`=0000, `ptr` unchanged.
  - Then `rsp_ready`=1: the next grant is taken in that same cycle.
- Pointer skip:
  - Stimulus: after a grant to requester 2, only requesters 1 and 3 are valid.
  - Response: grant 3, then grant 1.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 while `rsp_valid`=1 and `rsp_ready`=0.
  - Response: outputs reach reset values immediately without a clock edge; after release with requesters 2 and 0 valid, requester 0 is granted first.
- Counter wrap:
  - Stimulus: 65536 accepts.
  - Response: `txn_count` returns to 0; accepts and results are unaffected.
